// File: rtl/ltpi_pkg.sv
// Shared LTPI types: link states, data-channel payload and command encodings.
package ltpi_pkg;

  typedef enum logic [3:0] {
    link_detect_st  = 4'd0,
    link_speed_st   = 4'd1,
    advertise_st    = 4'd2,
    configure_st    = 4'd3,
    accept_st       = 4'd4,
    operational_st  = 4'd5,
    link_lost_st    = 4'd6
  } link_state_t;

  // Data-channel command encodings
  localparam logic [7:0] READ_REQ   = 8'h00;
  localparam logic [7:0] WRITE_REQ  = 8'h01;
  localparam logic [7:0] READ_COMP  = 8'h02;
  localparam logic [7:0] WRITE_COMP = 8'h03;
  localparam logic [7:0] CRC_ERROR  = 8'h04;

  typedef struct packed {
    logic [7:0]  command;
    logic [7:0]  tag;
    logic [31:0] address;
    logic [31:0] data;
  } Data_channel_payload_t;

  // Default depth of the data-channel response queue
  localparam int DC_RESP_FIFO_DEPTH = 4;

endpackage

// File: rtl/ltpi_dc_sync_fifo.sv
// Single-clock FIFO of data-channel payloads. Storage is unreset; the level
// counter guards every read so stale entries are never presented.
module ltpi_dc_sync_fifo
  import ltpi_pkg::*;
#(
  parameter int DEPTH = DC_RESP_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    flush,
  input  logic                    push,
  input  Data_channel_payload_t   push_data,
  input  logic                    pop,
  output Data_channel_payload_t   pop_data,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  Data_channel_payload_t r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;

  // Storage write; no reset so it maps onto plain RAM/registers
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign level    = r_level;

endmodule

// File: rtl/ltpi_data_channel_resp_tx.sv
// Response-side TX of the LTPI data channel: accepts completions from the
// target manager, queues them, and hands one out per frame-TX slot.
module ltpi_data_channel_resp_tx
  import ltpi_pkg::*;
#(
  parameter int FIFO_DEPTH = DC_RESP_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_channel_rst,
  input  link_state_t                  local_link_state,
  input  Data_channel_payload_t        resp,
  input  logic                         resp_valid,
  output logic                         resp_ack,
  input  logic                         tx_frm_req,
  output Data_channel_payload_t        tx_payload,
  output logic                         tx_payload_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  sent_cnt
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  w_arst;
  logic                  w_op;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [LW-1:0]         w_level;
  Data_channel_payload_t w_head;

  logic                  r_resp_ack;
  Data_channel_payload_t r_tx_payload;
  logic                  r_tx_payload_valid;
  logic [15:0]           r_sent_cnt;

  // Either reset source clears everything immediately
  assign w_arst  = reset | data_channel_rst;
  assign w_op    = (local_link_state == operational_st);
  // Full/empty come from the level at the start of the cycle, so a pop in
  // the same cycle never opens room for a push at full.
  assign w_full  = (w_level == LW'(FIFO_DEPTH));
  assign w_empty = (w_level == '0);
  // Ack cycle blocks a push so a held resp_valid is not taken twice
  assign w_push  = resp_valid & ~r_resp_ack & ~w_full & w_op;
  assign w_pop   = tx_frm_req & ~w_empty & w_op;

  ltpi_dc_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst      (w_arst),
    .flush     (~w_op),
    .push      (w_push),
    .push_data (resp),
    .pop       (w_pop),
    .pop_data  (w_head),
    .level     (w_level)
  );

  // Acceptance pulse one cycle after each push
  always_ff @(posedge clk or posedge w_arst) begin
    if (w_arst) begin
      r_resp_ack <= 1'b0;
    end else begin
      r_resp_ack <= w_push;
    end
  end

  // Frame slot: present the head (or an idle zero payload), held between strobes
  always_ff @(posedge clk or posedge w_arst) begin
    if (w_arst) begin
      r_tx_payload       <= '0;
      r_tx_payload_valid <= 1'b0;
      r_sent_cnt         <= '0;
    end else if (!w_op) begin
      r_tx_payload       <= '0;
      r_tx_payload_valid <= 1'b0;
    end else if (tx_frm_req) begin
      if (!w_empty) begin
        r_tx_payload       <= w_head;
        r_tx_payload_valid <= 1'b1;
        if (r_sent_cnt != 16'hFFFF) begin
          r_sent_cnt <= r_sent_cnt + 16'd1;
        end
      end else begin
        r_tx_payload       <= '0;
        r_tx_payload_valid <= 1'b0;
      end
    end
  end

  assign resp_ack         = r_resp_ack;
  assign tx_payload       = r_tx_payload;
  assign tx_payload_valid = r_tx_payload_valid;
  assign fifo_level       = w_level;
  assign sent_cnt         = r_sent_cnt;

endmodule

// File: tb/tb_ltpi_data_channel_resp_tx.sv
// Bench for ltpi_data_channel_resp_tx: directed scenarios followed by random
// traffic, each cycle compared against a transaction-level queue model.
module tb_ltpi_data_channel_resp_tx;
  import ltpi_pkg::*;

  localparam int D = DC_RESP_FIFO_DEPTH;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      data_channel_rst;
  link_state_t               local_link_state;
  Data_channel_payload_t     resp;
  logic                      resp_valid;
  logic                      resp_ack;
  logic                      tx_frm_req;
  Data_channel_payload_t     tx_payload;
  logic                      tx_payload_valid;
  logic [$clog2(D):0]        fifo_level;
  logic [15:0]               sent_cnt;

  ltpi_data_channel_resp_tx #(.FIFO_DEPTH(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .data_channel_rst (data_channel_rst),
    .local_link_state (local_link_state),
    .resp             (resp),
    .resp_valid       (resp_valid),
    .resp_ack         (resp_ack),
    .tx_frm_req       (tx_frm_req),
    .tx_payload       (tx_payload),
    .tx_payload_valid (tx_payload_valid),
    .fifo_level       (fifo_level),
    .sent_cnt         (sent_cnt)
  );

  always #5 clk = ~clk;

  // Producer backlog and reference model state
  Data_channel_payload_t src_q[$];
  Data_channel_payload_t mq[$];
  logic                  m_ack;
  logic                  m_valid;
  Data_channel_payload_t m_pl;
  logic [15:0]           m_cnt;
  link_state_t           link;

  int n_pass  = 0;
  int n_total = 0;

  function automatic Data_channel_payload_t mk(input logic [7:0] cmd, input logic [7:0] tag,
                                               input logic [31:0] addr, input logic [31:0] dat);
    Data_channel_payload_t p;
    p.command = cmd;
    p.tag     = tag;
    p.address = addr;
    p.data    = dat;
    return p;
  endfunction

  function automatic Data_channel_payload_t rnd_item();
    return mk(($urandom_range(0, 1) == 0) ? READ_COMP : WRITE_COMP,
              8'($urandom), 32'($urandom), 32'($urandom));
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("resp_ack",         128'(resp_ack),         128'(m_ack));
    chk("fifo_level",       128'(fifo_level),       128'(mq.size()));
    chk("tx_payload_valid", 128'(tx_payload_valid), 128'(m_valid));
    chk("tx_payload",       128'(tx_payload),       128'(m_pl));
    chk("sent_cnt",         128'(sent_cnt),         128'(m_cnt));
  endtask

  // Next-state of the model from the behavioural rules of the block
  task automatic model_step(input logic frm, input logic rv, input Data_channel_payload_t item,
                            input logic op);
    int   lvl;
    logic push;
    lvl  = mq.size();
    push = rv && !m_ack && (lvl < D) && op;
    if (!op) begin
      mq.delete();
      m_ack   = 1'b0;
      m_valid = 1'b0;
      m_pl    = '0;
    end else begin
      if (frm) begin
        if (lvl > 0) begin
          m_pl    = mq.pop_front();
          m_valid = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          m_pl    = '0;
          m_valid = 1'b0;
        end
      end
      if (push) mq.push_back(item);
      m_ack = push;
    end
  endtask

  // One clock: check at the negedge, drive inputs, advance model, wait
  task automatic cycle(input logic frm);
    check_outputs();
    if (m_ack && src_q.size() > 0) void'(src_q.pop_front());
    resp_valid       = (src_q.size() > 0);
    resp             = resp_valid ? src_q[0] : '0;
    tx_frm_req       = frm;
    local_link_state = link;
    model_step(frm, resp_valid, resp, link == operational_st);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic frm);
    for (int i = 0; i < n; i++) cycle(frm);
  endtask

  task automatic async_rst();
    #2;
    data_channel_rst = 1'b1;
    #1;
    chk("arst_resp_ack",   128'(resp_ack),         128'(0));
    chk("arst_level",      128'(fifo_level),       128'(0));
    chk("arst_valid",      128'(tx_payload_valid), 128'(0));
    chk("arst_payload",    128'(tx_payload),       128'(0));
    chk("arst_sent_cnt",   128'(sent_cnt),         128'(0));
    src_q.delete();
    mq.delete();
    m_ack = 1'b0; m_valid = 1'b0; m_pl = '0; m_cnt = '0;
    resp_valid = 1'b0; resp = '0; tx_frm_req = 1'b0;
    @(negedge clk);
    data_channel_rst = 1'b0;
  endtask

  initial begin
    Data_channel_payload_t single;
    reset = 1'b1; data_channel_rst = 1'b0;
    link = operational_st; local_link_state = operational_st;
    resp = '0; resp_valid = 1'b0; tx_frm_req = 1'b0;
    m_ack = 1'b0; m_valid = 1'b0; m_pl = '0; m_cnt = '0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Single push/pop
    single = mk(READ_COMP, 8'd3, 32'h0000_0010, 32'hDEAD_BEEF);
    src_q.push_back(single);
    run(3, 1'b0);
    cycle(1'b1);
    chk("single_payload", 128'(tx_payload), 128'(single));
    chk("single_cnt",     128'(sent_cnt),   128'(1));
    run(2, 1'b0);

    // Empty slot
    cycle(1'b1);
    chk("empty_valid", 128'(tx_payload_valid), 128'(0));
    chk("empty_cnt",   128'(sent_cnt),         128'(1));

    // Full stall: five completions, no slots
    for (int t = 0; t < 5; t++) src_q.push_back(mk(READ_COMP, 8'(t), 32'(t * 4), 32'(t)));
    run(12, 1'b0);
    chk("full_level", 128'(fifo_level), 128'(D));
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1);
      chk("stall_order", 128'(tx_payload.tag), 128'(t));
      run(3, 1'b0);
    end

    // Simultaneous push and pop at level 2
    src_q.push_back(rnd_item());
    src_q.push_back(rnd_item());
    run(5, 1'b0);
    src_q.push_back(rnd_item());
    cycle(1'b1);
    chk("simul_level", 128'(fifo_level), 128'(2));
    run(2, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    run(2, 1'b0);

    // Link drop with three queued
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_item());
    run(7, 1'b0);
    link = link_lost_st;
    run(2, 1'b1);
    chk("drop_level", 128'(fifo_level),       128'(0));
    chk("drop_valid", 128'(tx_payload_valid), 128'(0));
    link = operational_st;
    run(4, 1'b0);
    cycle(1'b1);
    run(2, 1'b0);

    // Asynchronous data-channel reset with two queued
    for (int i = 0; i < 2; i++) src_q.push_back(rnd_item());
    run(5, 1'b0);
    chk("pre_arst_level", 128'(fifo_level), 128'(2));
    async_rst();
    run(2, 1'b1);
    chk("post_arst_valid", 128'(tx_payload_valid), 128'(0));

    // Random traffic: a phase with frequent slots, one with rare slots
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 2) == 0 && src_q.size() < 3) src_q.push_back(rnd_item());
        if (link == operational_st) begin
          if ($urandom_range(0, 80) == 0) link = link_lost_st;
        end else if ($urandom_range(0, 3) == 0) begin
          link = operational_st;
        end
        cycle((ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
      end
    end
    link = operational_st;
    run(2, 1'b0);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
